// File: rtl/jogo_pkg.sv
// Shared types and constants for the Bulls & Cows board front-end and game core.
package jogo_pkg;

   localparam int unsigned CODE_W           = 16;
   localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CNT,
      HELD,
      REL_CNT
   } cond_state_t;

endpackage

// File: rtl/sync_chain.sv
// WIDTH x STAGES flip-flop synchronizer with synchronous active-high reset.
module sync_chain #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the enter button and latches a switch snapshot
// together with a single-cycle pulse for every accepted press.
module input_conditioner
   import jogo_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enter_raw,
   input  logic [CODE_W-1:0] code_raw,
   output logic              enter_pulse,
   output logic [CODE_W-1:0] code_out,
   output logic              btn_held
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic              btn_s;
   logic [CODE_W-1:0] code_s;

   cond_state_t       state, next_state;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic              pulse_next;
   logic [CODE_W-1:0] code_next;

   sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_btn (
      .clock (clock),
      .reset (reset),
      .d     (enter_raw),
      .q     (btn_s)
   );

   sync_chain #(.WIDTH(CODE_W), .STAGES(SYNC_STAGES)) u_sync_code (
      .clock (clock),
      .reset (reset),
      .d     (code_raw),
      .q     (code_s)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         enter_pulse <= 1'b0;
         code_out    <= '0;
      end else begin
         state       <= next_state;
         cnt         <= cnt_next;
         enter_pulse <= pulse_next;
         code_out    <= code_next;
      end
   end

   // Counter is cleared on every state entry, so it never needs to wrap.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      pulse_next = 1'b0;
      code_next  = code_out;
      case (state)
         IDLE: begin
            if (btn_s) begin
               next_state = PRESS_CNT;
               cnt_next   = '0;
            end
         end
         PRESS_CNT: begin
            if (!btn_s) begin
               next_state = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               next_state = HELD;
               cnt_next   = '0;
               pulse_next = 1'b1;
               code_next  = code_s;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!btn_s) begin
               next_state = REL_CNT;
               cnt_next   = '0;
            end
         end
         REL_CNT: begin
            if (btn_s) begin
               next_state = HELD;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               next_state = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         default: begin
            next_state = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign btn_held = (state == HELD) || (state == REL_CNT);

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized and directed bench for input_conditioner with a run-length
// debounce reference model and a pulse/snapshot scoreboard.
module tb_input_conditioner;

   localparam int unsigned DB = 4;
   localparam int unsigned SS = 2;

   logic        clock;
   logic        reset;
   logic        enter_raw;
   logic [15:0] code_raw;
   logic        enter_pulse;
   logic [15:0] code_out;
   logic        btn_held;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   bit          checking    = 0;

   input_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
      .clock       (clock),
      .reset       (reset),
      .enter_raw   (enter_raw),
      .code_raw    (code_raw),
      .enter_pulse (enter_pulse),
      .code_out    (code_out),
      .btn_held    (btn_held)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: the debounced level flips once the synchronized button has
   // disagreed with it for DB+1 consecutive edges; a 0->1 flip is a press.
   logic        hb [SS];
   logic [15:0] hc [SS];
   logic        m_level;
   int unsigned m_run;
   logic        m_pulse;
   logic [15:0] m_code;
   logic [15:0] exp_q [$];

   always @(posedge clock) begin
      logic        b;
      logic [15:0] cs;
      if (reset) begin
         for (int i = 0; i < SS; i++) begin
            hb[i] = 1'b0;
            hc[i] = 16'h0000;
         end
         m_level = 1'b0;
         m_run   = 0;
         m_pulse = 1'b0;
         m_code  = 16'h0000;
      end else begin
         b       = hb[SS-1];
         cs      = hc[SS-1];
         m_pulse = 1'b0;
         if (b == m_level) begin
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == DB + 1) begin
               m_level = b;
               m_run   = 0;
               if (b) begin
                  m_pulse = 1'b1;
                  m_code  = cs;
                  exp_q.push_back(cs);
               end
            end
         end
         for (int i = SS - 1; i > 0; i--) begin
            hb[i] = hb[i-1];
            hc[i] = hc[i-1];
         end
         hb[0] = enter_raw;
         hc[0] = code_raw;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clock) begin
      logic [15:0] want;
      if (checking) begin
         check("btn_held", {15'd0, btn_held}, {15'd0, m_level});
         check("enter_pulse", {15'd0, enter_pulse}, {15'd0, m_pulse});
         check("code_out", code_out, m_code);
         if (enter_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_pulse", 16'd1, 16'd0);
            end else begin
               want = exp_q.pop_front();
               check("pulse_snapshot", code_out, want);
            end
         end
      end
   end

   task automatic drive(input logic e, input logic [15:0] c, input int unsigned n);
      enter_raw = e;
      code_raw  = c;
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      enter_raw = 1'b0;
      code_raw  = 16'h0000;
      @(negedge clock);
      checking = 1;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Clean press held 20 cycles
      drive(1'b0, 16'h1234, 7);
      drive(1'b1, 16'h1234, 20);
      drive(1'b0, 16'h1234, 12);
      // Press bounce that never settles
      drive(1'b1, 16'hAAAA, 2);
      drive(1'b0, 16'hAAAA, 1);
      drive(1'b1, 16'hAAAA, 3);
      drive(1'b0, 16'hAAAA, 10);
      // Switch movement while held is ignored until the next press
      drive(1'b1, 16'h1234, 8);
      drive(1'b1, 16'h9876, 4);
      drive(1'b0, 16'h9876, 10);
      drive(1'b1, 16'h9876, 8);
      drive(1'b0, 16'h9876, 10);
      // Release bounce absorbed
      drive(1'b1, 16'h5555, 8);
      drive(1'b0, 16'h5555, 2);
      drive(1'b1, 16'h5555, 1);
      drive(1'b0, 16'h5555, 12);
      // Reset mid-count and mid-hold with the button still down
      drive(1'b1, 16'h4321, 5);
      pulse_reset();
      drive(1'b1, 16'h4321, 10);
      pulse_reset();
      drive(1'b1, 16'h4321, 10);
      drive(1'b0, 16'h4321, 12);
      // Minimum spacing 10 gives two pulses, 9 gives one
      drive(1'b1, 16'h0F0F, 5);
      drive(1'b0, 16'h0F0F, 5);
      drive(1'b1, 16'hF0F0, 5);
      drive(1'b0, 16'hF0F0, 12);
      drive(1'b1, 16'h0A0A, 5);
      drive(1'b0, 16'h0A0A, 4);
      drive(1'b1, 16'hA0A0, 5);
      drive(1'b0, 16'hA0A0, 12);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) pulse_reset();
         drive(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 12));
      end
      drive(1'b0, 16'h0000, 15);

      checking = 0;
      check("pending_pulses", 16'(exp_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioner between the Nexys A7 board inputs and the Bulls & Cows game core. It synchronizes the raw `enter_button` pushbutton and the 16 `code` switches into the `clock` domain. It debounces the button and emits exactly one single-cycle `enter_pulse` per physical press. At that same edge it freezes a snapshot of the switches, so the game core only ever sees a clean, stable guess paired with each press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a level change. At 100 MHz this is 10 ms. Must be ≥ 1.
- `SYNC_STAGES`, default 2: flip-flop depth of the synchronizers. Must be ≥ 2.

Ports:
- `clock`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous, active-high.
- `enter_raw`  in  1: asynchronous pushbutton level, active-high.
- `code_raw`  in  16: asynchronous switch levels, 4 hex digits.
- `enter_pulse`  out  1: one-cycle strobe per accepted press. Feeds the game core's `enter_button`.
- `code_out`  out  16: switch snapshot taken at the accepted press. Feeds the game core's `code`.
- `btn_held`  out  1: high while the FSM is in HELD or REL_CNT (debounced button is down).

## Operation
Synchronizers:
- `enter_raw` and each `code_raw` bit pass through a `SYNC_STAGES`-deep FF chain.
- The chain outputs are `btn_s` and `code_s`.

Debounce FSM states: IDLE, PRESS_CNT, HELD, REL_CNT.
- **IDLE**
  - `btn_s`=1: go to PRESS_CNT, counter=0.
- **PRESS_CNT**
  - `btn_s`=0: back to IDLE, counter cleared. This is a glitch; no pulse, `code_out` unchanged.
  - `btn_s`=1 and counter == `DEBOUNCE_CYCLES`−1: go to HELD.
    - On that same edge: `enter_pulse`←1 and `code_out`←`code_s`.
  - Otherwise: counter+1.
- **HELD**
  - `btn_s`=0: go to REL_CNT, counter=0.
  - No further pulses while held, however long.
- **REL_CNT**
  - `btn_s`=1: back to HELD, counter cleared. Release bounce is absorbed.
  - `btn_s`=0 and counter == `DEBOUNCE_CYCLES`−1: go to IDLE.
  - Otherwise: counter+1.

Counter:
- Unsigned, width `$clog2(DEBOUNCE_CYCLES+1)`.
- Never wraps: it is cleared on every state entry and saturates by transition.

Outputs:
- `enter_pulse` is a registered output, high for exactly one cycle per accepted press.
- `code_out` changes only on that same edge. Switch movement at any other time is invisible downstream.
- `btn_held`: 1 in HELD/REL_CNT, 0 in IDLE/PRESS_CNT.

Reset:
- Applies on any clock edge with `reset`=1, including mid-count and mid-hold.
- Result: state=IDLE, counter=0, `enter_pulse`=0, `code_out`=16'h0000, `btn_held`=0, all synchronizer FFs=0.
- If the button is still held when `reset` drops, a new press must be fully debounced before a pulse is issued. This is intended: a held button may re-fire once after reset.
- Simultaneous `reset` and pulse condition: reset wins, no pulse.

## Timing
- Press latency: the button rises and stays stable at edge t. `btn_s` rises at t+`SYNC_STAGES`. `enter_pulse`=1 during cycle t+`SYNC_STAGES`+`DEBOUNCE_CYCLES`.
- Switch sampling: `code_out` reflects `code_raw` as it was `SYNC_STAGES` cycles before the pulse edge.
- Minimum spacing between two pulses is 2·`DEBOUNCE_CYCLES`+2 cycles: full press debounce, one HELD cycle, full release debounce.
- No backpressure: the consumer must accept `enter_pulse` in the cycle it is high.

## Structure
- Shared package `jogo_pkg` holds:
  - `CODE_W`=16.
  - The `cond_state_t` enum {IDLE, PRESS_CNT, HELD, REL_CNT}.
  - The `DEBOUNCE_DEFAULT` constant.
- One sub-module, `sync_chain`: a parameterized width×`SYNC_STAGES` FF synchronizer with synchronous reset.
  - Instantiated once for the button (width 1).
  - Instantiated once for the switches (width `CODE_W`).
- The FSM, counter and output registers live in `input_conditioner`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2.
1. `code_raw`=16'h1234; `enter_raw` goes 0→1 at edge 10 and is held 20 cycles → exactly one `enter_pulse`, at cycle 16; `code_out`=16'h1234 from cycle 16; `btn_held`=1 from cycle 16.
2. `enter_raw` bounces: 1 for 2 cycles, 0 for 1 cycle, 1 for 3 cycles, then 0 → no `enter_pulse`; `code_out` keeps its prior value.
3. Press accepted, then `code_raw` changes to 16'h9876 while held → `code_out` stays 16'h1234; a second full press/release then yields `code_out`=16'h9876.
4. Release bounce after HELD (0 for 2 cycles, 1 for 1, 0 for 6) → no second pulse; FSM reaches IDLE 4 cycles after the last `btn_s` fall.
5. `reset` asserted in PRESS_CNT at counter=3 → no pulse; all outputs 0 on the next edge; a held button after `reset` drops produces one pulse after a full 2+4-cycle latency.
6. Two clean presses spaced exactly 10 cycles apart (raw rise to raw rise) → two pulses 10 cycles apart; a 9-cycle spacing gives only one pulse.
